level_pipe: RTL and testbench

LEVEL_PIPE -- requirements
Module: level_pipe

---
 rtl/level_pipe.sv | 141 ++++++++++++++
 tb/tb_level_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/level_pipe.sv
// rtl/level_pipe.sv - one trie level: node lookup with WAYS-wide parallel key compare, 3-register pipeline
// Optional hit/miss counters enabled by defining LEVEL_PIPE_STATS_EN.
module level_pipe #(
    parameter int WORD_SIZE      = 16,
    parameter int POINTER_SIZE   = 16,
    parameter int MEM_SIZE       = 2,
    parameter int WAYS           = 4,
    parameter int LEVEL_ID       = 1,
    parameter     DATA_FILE_NAME = "level1.dat"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [POINTER_SIZE-1:0] address_in,
    input  logic [WORD_SIZE-1:0]    lookup_cont_in,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [POINTER_SIZE-1:0] next_pointer_out,
    output logic                    is_match_out,
    output logic                    no_child_out,
`ifdef LEVEL_PIPE_STATS_EN
    output logic [31:0]             hit_count_out,
    output logic [31:0]             miss_count_out,
    output logic [7:0]              level_id_out
`else
    output logic [7:0]              level_id_out
`endif
);

    localparam int ENTRY_W = 2 + WORD_SIZE + POINTER_SIZE;
    localparam int NODE_W  = WAYS * ENTRY_W;
    localparam int IDX_W   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef logic [MEM_SIZE-1:0][NODE_W-1:0] image_t;

    function automatic logic [ENTRY_W-1:0] make_entry(input bit v, input bit h,
                                                      input logic [15:0] key,
                                                      input logic [15:0] ptr);
        return {v, h, WORD_SIZE'(key), POINTER_SIZE'(ptr)};
    endfunction

    // Node images are compiled in; the file name selects which image this level holds.
    function automatic image_t level1_image();
        image_t img;
        img = '0;
        if (MEM_SIZE > 1 && WAYS > 3) begin
            img[0][0*ENTRY_W +: ENTRY_W] = make_entry(1'b1, 1'b0, 16'h6162, 16'h0003);
            img[0][1*ENTRY_W +: ENTRY_W] = make_entry(1'b1, 1'b1, 16'h7B7D, 16'h0001);
            img[0][3*ENTRY_W +: ENTRY_W] = make_entry(1'b0, 1'b1, 16'h7A7A, 16'h0009);
            img[1][0*ENTRY_W +: ENTRY_W] = make_entry(1'b1, 1'b0, 16'h2121, 16'h0000);
            img[1][1*ENTRY_W +: ENTRY_W] = make_entry(1'b1, 1'b1, 16'h4142, 16'h0007);
            img[1][2*ENTRY_W +: ENTRY_W] = make_entry(1'b1, 1'b1, 16'h2121, 16'h0005);
        end
        return img;
    endfunction

    localparam bit     USE_LEVEL1 = (DATA_FILE_NAME == "level1.dat");
    localparam image_t NODE_MEM   = USE_LEVEL1 ? level1_image() : '0;

    logic                    a_valid;
    logic [POINTER_SIZE-1:0] a_addr;
    logic [WORD_SIZE-1:0]    a_key;
    logic                    r_valid;
    logic [WORD_SIZE-1:0]    r_key;
    logic [NODE_W-1:0]       r_node;
    logic                    advance;
    logic                    a_in_range;

    logic                    hit;
    logic                    hit_child;
    logic [POINTER_SIZE-1:0] hit_ptr;
    logic [ENTRY_W-1:0]      ent;

    assign ready_out    = !valid_out || ready_in;
    assign advance      = ready_out;
    assign a_in_range   = 32'(a_addr) < MEM_SIZE;
    assign level_id_out = 8'(LEVEL_ID);

    // Lowest-index valid way with an equal key wins.
    always_comb begin
        hit       = 1'b0;
        hit_child = 1'b0;
        hit_ptr   = '0;
        ent       = '0;
        for (int w = 0; w < WAYS; w++) begin
            ent = r_node[w*ENTRY_W +: ENTRY_W];
            if (!hit && ent[ENTRY_W-1] && ent[POINTER_SIZE +: WORD_SIZE] == r_key) begin
                hit       = 1'b1;
                hit_child = ent[ENTRY_W-2];
                hit_ptr   = ent[POINTER_SIZE-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid          <= 1'b0;
            r_valid          <= 1'b0;
            valid_out        <= 1'b0;
            next_pointer_out <= '0;
            is_match_out     <= 1'b0;
            no_child_out     <= 1'b0;
        end else if (advance) begin
            a_valid <= valid_in;
            a_addr  <= address_in;
            a_key   <= lookup_cont_in;

            // An out-of-range address reads as an all-invalid node, so it resolves as a miss.
            r_valid <= a_valid;
            r_key   <= a_key;
            r_node  <= (a_valid && a_in_range) ? NODE_MEM[a_addr[IDX_W-1:0]] : '0;

            valid_out <= r_valid;
            if (r_valid) begin
                is_match_out     <= hit;
                next_pointer_out <= hit ? hit_ptr : '0;
                no_child_out     <= hit ? !hit_child : 1'b1;
            end else begin
                is_match_out     <= 1'b0;
                next_pointer_out <= '0;
                no_child_out     <= 1'b0;
            end
        end
    end

`ifdef LEVEL_PIPE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_out  <= '0;
            miss_count_out <= '0;
        end else if (valid_out && ready_in) begin
            if (is_match_out && hit_count_out != '1)
                hit_count_out <= hit_count_out + 32'd1;
            if (!is_match_out && miss_count_out != '1)
                miss_count_out <= miss_count_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_level_pipe.sv
// tb/tb_level_pipe.sv - table-driven scoreboard bench for level_pipe
module tb_level_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b1;
    logic [15:0] address_in = '0;
    logic [15:0] lookup_cont_in = '0;
    logic        ready_out;
    logic        valid_out;
    logic [15:0] next_pointer_out;
    logic        is_match_out;
    logic        no_child_out;
    logic [7:0]  level_id_out;
`ifdef LEVEL_PIPE_STATS_EN
    logic [31:0] hit_count_out;
    logic [31:0] miss_count_out;
`endif

    level_pipe dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .ready_out        (ready_out),
        .address_in       (address_in),
        .lookup_cont_in   (lookup_cont_in),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .next_pointer_out (next_pointer_out),
        .is_match_out     (is_match_out),
        .no_child_out     (no_child_out),
`ifdef LEVEL_PIPE_STATS_EN
        .hit_count_out    (hit_count_out),
        .miss_count_out   (miss_count_out),
`endif
        .level_id_out     (level_id_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic [15:0] p;
        logic        nc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] k;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   delivered = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got ptr %0h expected no result", next_pointer_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("is_match", 32'(is_match_out), 32'(e.m));
                check("next_pointer", 32'(next_pointer_out), 32'(e.p));
                check("no_child", 32'(no_child_out), 32'(e.nc));
                delivered++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge with valid_in still up.
    task automatic send(input logic [15:0] a, input logic [15:0] k, input exp_t e, input bit track);
        int n;
        address_in     = a;
        lookup_cont_in = k;
        valid_in       = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_out) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got ready_out 0 expected 1");
                break;
            end
        end
        if (track) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic latency(input logic [15:0] a, input logic [15:0] k, input exp_t e);
        address_in     = a;
        lookup_cont_in = k;
        valid_in       = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(negedge clk);
        check("latency_edge1", 32'(valid_out), 32'd0);
        @(negedge clk);
        check("latency_edge2_pre", 32'(valid_out), 32'd0);
        @(negedge clk);
        check("latency_edge2", 32'(valid_out), 32'd1);
        drain();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   d0;

        vecs[0] = '{16'h0000, 16'h7B7D, '{1'b1, 16'h0001, 1'b0}};
        vecs[1] = '{16'h0001, 16'h2121, '{1'b1, 16'h0000, 1'b1}};
        vecs[2] = '{16'h0001, 16'h5C6C, '{1'b0, 16'h0000, 1'b1}};
        vecs[3] = '{16'h0002, 16'h7B7D, '{1'b0, 16'h0000, 1'b1}};
        vecs[4] = '{16'h0000, 16'h6162, '{1'b1, 16'h0003, 1'b1}};
        vecs[5] = '{16'h0000, 16'h7A7A, '{1'b0, 16'h0000, 1'b1}};
        vecs[6] = '{16'h0001, 16'h4142, '{1'b1, 16'h0007, 1'b0}};
        vecs[7] = '{16'hFFFF, 16'h2121, '{1'b0, 16'h0000, 1'b1}};
        vecs[8] = '{16'h0000, 16'h2121, '{1'b0, 16'h0000, 1'b1}};

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid_out", 32'(valid_out), 32'd0);
        check("reset_next_pointer", 32'(next_pointer_out), 32'd0);
        check("reset_is_match", 32'(is_match_out), 32'd0);
        check("reset_no_child", 32'(no_child_out), 32'd0);
        check("reset_ready_out", 32'(ready_out), 32'd1);
        check("level_id", 32'(level_id_out), 32'd1);
        rst    = 1'b0;
        mon_en = 1'b1;

        latency(vecs[0].a, vecs[0].k, vecs[0].e);

        for (int i = 0; i < 9; i++) send(vecs[i].a, vecs[i].k, vecs[i].e, 1'b1);
        valid_in = 1'b0;
        drain();
        check("delivered_table", 32'(delivered), 32'd10);

        // Back-pressure: three queued results, downstream stalls for three cycles.
        d0 = delivered;
        send(vecs[0].a, vecs[0].k, vecs[0].e, 1'b1);
        send(vecs[6].a, vecs[6].k, vecs[6].e, 1'b1);
        send(vecs[4].a, vecs[4].k, vecs[4].e, 1'b1);
        valid_in = 1'b0;
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ready_out", 32'(ready_out), 32'd0);
            check("stall_valid_out", 32'(valid_out), 32'd1);
            check("stall_next_pointer", 32'(next_pointer_out), 32'h0001);
            check("stall_no_child", 32'(no_child_out), 32'd0);
        end
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        drain();
        check("delivered_stall", 32'(delivered - d0), 32'd3);

        // Reset with two requests in flight: neither may emerge.
        d0 = delivered;
        send(vecs[0].a, vecs[0].k, vecs[0].e, 1'b0);
        send(vecs[1].a, vecs[1].k, vecs[1].e, 1'b0);
        valid_in = 1'b0;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_valid_out", 32'(valid_out), 32'd0);
        end
        @(posedge clk);
        #1;
        check("flush_delivered", 32'(delivered - d0), 32'd0);
        latency(vecs[1].a, vecs[1].k, vecs[1].e);

`ifdef LEVEL_PIPE_STATS_EN
        pulse_reset();
        send(vecs[0].a, vecs[0].k, vecs[0].e, 1'b1);
        send(vecs[2].a, vecs[2].k, vecs[2].e, 1'b1);
        send(vecs[1].a, vecs[1].k, vecs[1].e, 1'b1);
        send(vecs[3].a, vecs[3].k, vecs[3].e, 1'b1);
        send(vecs[6].a, vecs[6].k, vecs[6].e, 1'b1);
        valid_in = 1'b0;
        drain();
        @(posedge clk);
        #1;
        check("hit_count", hit_count_out, 32'd3);
        check("miss_count", miss_count_out, 32'd2);
        pulse_reset();
        check("hit_count_reset", hit_count_out, 32'd0);
        check("miss_count_reset", miss_count_out, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
